arbitro_mux2a1: RTL and testbench
=================================

Name: arbitro_mux2a1

Overview:
- Round-robin scheduler for the 2:1, BW-bit mux datapath.
- Buffers two producer lanes (valid_0/data_in0, valid_1/data_in1) in per-lane FIFOs.
- Each cycle, picks which lane to forward, drives the mux `selector`, and produces a registered `valid_out`/`data_out` stream.
- Sits between the probador-style producers and the downstream consumer; replaces the externally driven `selector`.

Parameters:
- BW, 2, data width per lane and of `data_out`.
- DEPTH, 4, entries per lane FIFO (power of two, ≥2).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- valid_0  input  1  lane 0 push strobe.
- data_in0  input  BW  lane 0 data.
- valid_1  input  1  lane 1 push strobe.
- data_in1  input  BW  lane 1 data.
- pause  input  1  downstream stall; no pop while high.
- selector  output  1  lane whose word is on `data_out` (0/1), registered.
- valid_out  output  1  `data_out` holds a new word this cycle, registered.
- data_out  output  BW  forwarded word, registered.
- full_0  output  1  lane 0 FIFO count == DEPTH (combinational from count).
- full_1  output  1  lane 1 FIFO count == DEPTH.
- overflow_0  output  1  sticky: a lane 0 push was dropped.
- overflow_1  output  1  sticky: a lane 1 push was dropped.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - FIFOs emptied (pointers and counts 0).
  - selector=0, valid_out=0, data_out=0, overflow_0/1=0.
  - last_grant=1, so lane 0 wins first.
  - FSM=IDLE.
  - Assertion mid-operation discards all buffered words immediately, without waiting for a clock edge.
- Push:
  - At each edge, if valid_x=1 and count_x<DEPTH (count before the edge), data_in_x is written and count_x increments.
  - If count_x==DEPTH, the word is dropped and overflow_x sets. It is dropped even if lane x is popped on the same edge.
- Grant, evaluated on pre-edge counts:
  - Eligible lane = count_x>0.
  - Both eligible: grant the lane != last_grant.
  - One eligible: grant it.
  - None eligible: no grant.
  - last_grant updates only on an actual pop.
- Pop, when granted and pause=0:
  - Read head of the granted lane; count decrements, read pointer wraps modulo DEPTH.
  - Same edge: data_out<=head, selector<=granted lane, valid_out<=1.
- No pop: valid_out<=0; data_out and selector hold their previous values.
- Same-lane push and pop on one edge: count unchanged, both pointers advance.
- Latency: a word sampled at edge E0 into an empty, idle block appears on data_out with valid_out=1 after edge E1 (1 cycle). Throughput is 1 word/cycle total.
- FSM, registered:
  - IDLE: both FIFOs empty. Goes to ACTIVE when any count>0 after the edge.
  - ACTIVE: popping. Goes to PAUSED when pause=1 with data pending; goes to IDLE when both empty after the edge.
  - PAUSED: no pops. Goes to ACTIVE when pause=0; goes to IDLE only via reset.
  - Pushes continue in every state.
- Fairness: with both lanes continuously non-empty and pause=0, the selector sequence alternates 0,1,0,1…

Optional Feature:
- Macro: ARB_PRIORITY0_EN.
- Defined: strict priority. Lane 0 is granted whenever count_0>0; lane 1 only when lane 0 is empty. last_grant is unused.
- Undefined: round-robin as described above.
- All other behaviour (overflow, pause, latency) is identical in both builds.

Test Plan (BW=2, DEPTH=4):
- Reset, then valid_0=1 with data_in0=2'b10 for one cycle -> after the next edge: valid_out=1, data_out=2'b10, selector=0. The following cycle valid_out=0.
- Push lane0 {1,2,3} and lane1 {0,3,2} on the same 3 cycles, pause=0 -> output sequence (sel,data): (0,1),(1,0),(0,2),(1,3),(0,3),(1,2).
- pause=1, then 5 pushes to lane 1 of 0,1,2,3,0 -> full_1=1 after 4 pushes; the 5th is dropped and overflow_1=1. After pause=0: outputs 0,1,2,3 on selector=1, then valid_out=0; overflow_1 stays 1.
- Fill lane 0 to 2 entries, assert reset_L=0 mid-cycle -> outputs cleared asynchronously, before the next edge. After release, no valid_out without new pushes.
- pause toggled 1,0,1,0 with both lanes holding 2 words -> valid_out=1 only in cycles after pause=0 edges. Selector still alternates starting at 0.
- Build with ARB_PRIORITY0_EN; load lane0 {1,1} and lane1 {2} -> outputs (0,1),(0,1),(1,2).

Source files
------------

// File: rtl/arbitro_mux2a1.sv
// arbitro_mux2a1: two-lane FIFO-buffered round-robin mux arbiter (ARB_PRIORITY0_EN selects strict lane-0 priority)
module arbitro_mux2a1 #(
    parameter int BW    = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          valid_0,
    input  logic [BW-1:0] data_in0,
    input  logic          valid_1,
    input  logic [BW-1:0] data_in1,
    input  logic          pause,
    output logic          selector,
    output logic          valid_out,
    output logic [BW-1:0] data_out,
    output logic          full_0,
    output logic          full_1,
    output logic          overflow_0,
    output logic          overflow_1
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, PAUSED} state_t;
    logic [BW-1:0] mem0 [DEPTH];
    logic [BW-1:0] mem1 [DEPTH];
    logic [PW-1:0] wr0, rd0, wr1, rd1;
    logic [CW-1:0] cnt0, cnt1, cnt0_n, cnt1_n;
    logic          grant, any, any_n, pop, pop0, pop1, push0, push1;
    state_t        state, state_n;
    assign full_0 = cnt0 == CW'(DEPTH);
    assign full_1 = cnt1 == CW'(DEPTH);
    assign push0  = valid_0 && !full_0;
    assign push1  = valid_1 && !full_1;
    assign any    = (cnt0 != '0) || (cnt1 != '0);
`ifdef ARB_PRIORITY0_EN
    assign grant = cnt0 == '0;
`else
    logic last_grant;
    // when both lanes are eligible, grant the lane not served last
    assign grant = (cnt0 != '0 && cnt1 != '0) ? ~last_grant : (cnt1 != '0);
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) last_grant <= 1'b1;
        else if (pop) last_grant <= grant;
`endif
    assign pop    = any && !pause;
    assign pop0   = pop && !grant;
    assign pop1   = pop && grant;
    assign cnt0_n = cnt0 + CW'(push0) - CW'(pop0);
    assign cnt1_n = cnt1 + CW'(push1) - CW'(pop1);
    assign any_n  = (cnt0_n != '0) || (cnt1_n != '0);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any_n ? ACTIVE : IDLE;
            ACTIVE:  state_n = (pause && any_n) ? PAUSED : (any_n ? ACTIVE : IDLE);
            PAUSED:  state_n = pause ? PAUSED : ACTIVE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push0) mem0[wr0] <= data_in0;
        if (push1) mem1[wr1] <= data_in1;
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr0        <= '0;
            rd0        <= '0;
            wr1        <= '0;
            rd1        <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            selector   <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            overflow_0 <= 1'b0;
            overflow_1 <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push0) wr0 <= wr0 + 1'b1;
            if (push1) wr1 <= wr1 + 1'b1;
            if (pop0) rd0 <= rd0 + 1'b1;
            if (pop1) rd1 <= rd1 + 1'b1;
            cnt0       <= cnt0_n;
            cnt1       <= cnt1_n;
            overflow_0 <= overflow_0 | (valid_0 && full_0);
            overflow_1 <= overflow_1 | (valid_1 && full_1);
            valid_out  <= pop;
            if (pop) begin
                selector <= grant;
                data_out <= grant ? mem1[rd1] : mem0[rd0];
            end
            state <= state_n;
        end
    end
endmodule

// File: tb/tb_arbitro_mux2a1.sv
// tb_arbitro_mux2a1: directed scoreboard bench for arbitro_mux2a1 (BW=2, DEPTH=4)
module tb_arbitro_mux2a1;
    localparam int BW = 2;
    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          valid_0 = 1'b0, valid_1 = 1'b0, pause = 1'b0;
    logic [BW-1:0] data_in0 = '0, data_in1 = '0;
    logic          selector, valid_out, full_0, full_1, overflow_0, overflow_1;
    logic [BW-1:0] data_out;
    logic [BW:0]   sb [$];
    int            n_cmp = 0, n_err = 0;

    arbitro_mux2a1 #(.BW(BW), .DEPTH(4)) dut (
        .clk(clk), .reset_L(reset_L),
        .valid_0(valid_0), .data_in0(data_in0),
        .valid_1(valid_1), .data_in1(data_in1),
        .pause(pause), .selector(selector), .valid_out(valid_out), .data_out(data_out),
        .full_0(full_0), .full_1(full_1), .overflow_0(overflow_0), .overflow_1(overflow_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then retire any produced word against the scoreboard
    task automatic tick();
        logic [BW:0] e;
        @(posedge clk);
        #1;
        if (valid_out) begin
            if (sb.size() == 0) chk("unexpected_valid", 8'(valid_out), 8'd0);
            else begin
                e = sb.pop_front();
                chk("selector", 8'(selector), 8'(e[BW]));
                chk("data_out", 8'(data_out), 8'(e[BW-1:0]));
            end
        end
    endtask

    task automatic do_reset();
        valid_0 = 0; valid_1 = 0; pause = 0;
        reset_L = 0;
        @(posedge clk);
        #1;
        reset_L = 1;
    endtask

    task automatic drain_check(input string tag);
        chk(tag, 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    initial begin
        #1;
        chk("rst_valid_out", 8'(valid_out), 8'd0);
        chk("rst_data_out", 8'(data_out), 8'd0);
        chk("rst_selector", 8'(selector), 8'd0);
        chk("rst_full", 8'({full_1, full_0}), 8'd0);
        chk("rst_overflow", 8'({overflow_1, overflow_0}), 8'd0);
        @(posedge clk);
        #1;
        reset_L = 1;

        // single word, one-cycle latency
        sb.push_back({1'b0, 2'b10});
        valid_0 = 1; data_in0 = 2'b10;
        tick();
        chk("t1_no_out_yet", 8'(valid_out), 8'd0);
        valid_0 = 0;
        tick();
        chk("t1_valid", 8'(valid_out), 8'd1);
        tick();
        chk("t1_valid_drop", 8'(valid_out), 8'd0);
        drain_check("t1_drained");

        // simultaneous pushes on both lanes
        do_reset();
`ifdef ARB_PRIORITY0_EN
        foreach (sb[i]) ;
        sb.push_back({1'b0, 2'd1}); sb.push_back({1'b0, 2'd2}); sb.push_back({1'b0, 2'd3});
        sb.push_back({1'b1, 2'd0}); sb.push_back({1'b1, 2'd3}); sb.push_back({1'b1, 2'd2});
`else
        sb.push_back({1'b0, 2'd1}); sb.push_back({1'b1, 2'd0}); sb.push_back({1'b0, 2'd2});
        sb.push_back({1'b1, 2'd3}); sb.push_back({1'b0, 2'd3}); sb.push_back({1'b1, 2'd2});
`endif
        valid_0 = 1; valid_1 = 1;
        data_in0 = 2'd1; data_in1 = 2'd0; tick();
        data_in0 = 2'd2; data_in1 = 2'd3; tick();
        data_in0 = 2'd3; data_in1 = 2'd2; tick();
        valid_0 = 0; valid_1 = 0;
        repeat (5) tick();
        chk("t2_idle", 8'(valid_out), 8'd0);
        drain_check("t2_drained");

        // fill lane 1 under pause, overflow on the fifth push
        do_reset();
        pause = 1; valid_1 = 1;
        for (int i = 0; i < 4; i++) begin
            data_in1 = BW'(i);
            sb.push_back({1'b1, BW'(i)});
            tick();
            chk("t3_paused", 8'(valid_out), 8'd0);
        end
        chk("t3_full_1", 8'(full_1), 8'd1);
        chk("t3_no_ovf_yet", 8'(overflow_1), 8'd0);
        data_in1 = 2'd0;
        tick();
        chk("t3_overflow_1", 8'(overflow_1), 8'd1);
        chk("t3_overflow_0", 8'(overflow_0), 8'd0);
        valid_1 = 0; pause = 0;
        repeat (4) tick();
        chk("t3_full_cleared", 8'(full_1), 8'd0);
        tick();
        chk("t3_end_valid", 8'(valid_out), 8'd0);
        chk("t3_ovf_sticky", 8'(overflow_1), 8'd1);
        drain_check("t3_drained");

        // asynchronous reset while words are buffered
        do_reset();
        pause = 1; valid_0 = 1;
        data_in0 = 2'd3; sb.push_back({1'b0, 2'd3}); tick();
        data_in0 = 2'd1; tick();
        data_in0 = 2'd2; tick();
        valid_0 = 0; pause = 0;
        tick();
        chk("t4_pre_valid", 8'(valid_out), 8'd1);
        pause = 1;
        #3;
        reset_L = 0;
        #1;
        chk("t4_async_valid", 8'(valid_out), 8'd0);
        chk("t4_async_data", 8'(data_out), 8'd0);
        chk("t4_async_sel", 8'(selector), 8'd0);
        #1;
        reset_L = 1; pause = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_output", 8'(valid_out), 8'd0);
        end
        drain_check("t4_drained");

        // pause toggling with two words per lane
        do_reset();
        pause = 1; valid_0 = 1; valid_1 = 1;
        data_in0 = 2'd1; data_in1 = 2'd3; tick();
        data_in0 = 2'd2; data_in1 = 2'd0; tick();
        valid_0 = 0; valid_1 = 0;
`ifdef ARB_PRIORITY0_EN
        sb.push_back({1'b0, 2'd1}); sb.push_back({1'b0, 2'd2});
        sb.push_back({1'b1, 2'd3}); sb.push_back({1'b1, 2'd0});
`else
        sb.push_back({1'b0, 2'd1}); sb.push_back({1'b1, 2'd3});
        sb.push_back({1'b0, 2'd2}); sb.push_back({1'b1, 2'd0});
`endif
        for (int i = 0; i < 8; i++) begin
            pause = (i % 2 == 0);
            tick();
            chk("t5_valid_vs_pause", 8'(valid_out), 8'(!pause));
        end
        drain_check("t5_drained");

        // lane0 {1,1} and lane1 {2}
        do_reset();
`ifdef ARB_PRIORITY0_EN
        sb.push_back({1'b0, 2'd1}); sb.push_back({1'b0, 2'd1}); sb.push_back({1'b1, 2'd2});
`else
        sb.push_back({1'b0, 2'd1}); sb.push_back({1'b1, 2'd2}); sb.push_back({1'b0, 2'd1});
`endif
        valid_0 = 1; data_in0 = 2'd1; valid_1 = 1; data_in1 = 2'd2;
        tick();
        valid_1 = 0;
        tick();
        valid_0 = 0;
        repeat (4) tick();
        drain_check("t6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
